cal_angle_arbiter: RTL
======================

Name: cal_angle_arbiter

Overview:
- Shares one CalAngle instance (8-bit real/imag in, 16-bit angle out, valid-only, no backpressure) among NUM_CH sample sources.
- Round-robin arbitration issues at most one sample per cycle into CalAngle.
- Each issued sample's channel ID is pushed into an in-order tag FIFO.
- Each CalAngle result pops a tag and is returned with its channel ID.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- CH_W, $clog2(NUM_CH), channel-ID width.
- MAX_INFLIGHT, 32, tag FIFO depth; must be ≥ CalAngle latency + 1; power of two.
- PIPE_LAT, 24, CalAngle worst-case latency in cycles; used for the post-reset drain.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_val_i  in  NUM_CH  per-channel sample valid.
- req_rdy_o  out  NUM_CH  per-channel grant; a sample transfers when val & rdy.
- req_real_i  in  NUM_CH*8  packed real samples; channel k at [8k+7:8k].
- req_imag_i  in  NUM_CH*8  packed imag samples.
- cal_val_o  out  1  to CalAngle val_i.
- cal_real_o  out  8  to CalAngle real_i.
- cal_imag_o  out  8  to CalAngle imag_i.
- cal_val_i  in  1  from CalAngle val_o.
- cal_angle_i  in  16  from CalAngle angle_o.
- res_val_o  out  1  result valid, one-cycle pulse.
- res_ch_o  out  CH_W  channel ID of the result.
- res_angle_o  out  16  angle result.
- inflight_o  out  $clog2(MAX_INFLIGHT)+1  current tag FIFO occupancy.
- err_o  out  1  sticky: result arrived with tag FIFO empty in RUN.

Behaviour:
- Reset values: all outputs 0; RR pointer 0; FIFO empty; err_o 0; FSM in DRAIN.
- FSM states:
  - DRAIN: counter runs PIPE_LAT cycles; req_rdy_o = 0; cal_val_i ignored with no err. Exits to RUN on terminal count. Purpose: flush CalAngle, which has no reset.
  - RUN: normal operation. No exit except rst_n.
- Grant (RUN only):
  - Issuing is allowed when (count − pop) < MAX_INFLIGHT, where pop = cal_val_i & FIFO non-empty. Simultaneous push and pop while full is therefore legal.
  - When allowed, exactly one req_rdy_o bit asserts: the first requesting channel at or after the RR pointer (combinational from req_val_i).
  - When not allowed, req_rdy_o = 0.
  - req_rdy_o is 0 for any channel not requesting.
- RR pointer: on a transfer from channel g, pointer ← (g+1) mod NUM_CH; otherwise unchanged.
- Issue latency: transfer at cycle t → cal_val_o = 1 at t+1, with cal_real_o/cal_imag_o registered from the granted channel. With no transfer, cal_val_o = 0 and data holds its last value.
- Tag push: with the same transfer, g is pushed to the FIFO.
- Return latency: cal_val_i at cycle u with FIFO non-empty → at u+1, res_val_o = 1, res_angle_o = cal_angle_i, res_ch_o = popped tag. Results stay in issue order.
- cal_val_i in RUN with FIFO empty: result discarded; err_o ← 1 until reset.
- inflight_o = registered FIFO count, updated each cycle by push − pop.
- Reset mid-operation: everything clears asynchronously and the FSM re-enters DRAIN. Stale CalAngle outputs arriving during DRAIN are dropped silently.
- Throughput: one sample per cycle sustained when the FIFO is not limiting.

Decomposition:
- Shared package cal_angle_pkg:
  - DATA_W = 8, ANGLE_W = 16.
  - State enum {DRAIN, RUN}.
  - Function rr_pick(req, ptr) returning the grant index.
- One sub-module: tag_fifo, a synchronous FIFO with parameters WIDTH = CH_W, DEPTH = MAX_INFLIGHT; ports push/pop/din/dout/count/empty/full; async active-low reset.

Test Plan:
1. Reset, then hold req_val_i = 4'b1111 → req_rdy_o = 0 for PIPE_LAT = 24 cycles, then grants in order 0,1,2,3,0,… one per cycle; cal_val_o continuous.
2. Only channel 2 requests, real = 8'h40, imag = 8'hC0 → cal_val_o at the cycle after the grant with those values. CalAngle model returns 16'h1234 → res_val_o = 1, res_ch_o = 2, res_angle_o = 16'h1234 one cycle after cal_val_i.
3. Stall the CalAngle model output with all channels requesting → exactly 32 transfers, then req_rdy_o = 0 and inflight_o = 32. Release one result → exactly one new grant in that same cycle; inflight_o stays 32.
4. Pulse cal_val_i with the FIFO empty in RUN → res_val_o stays 0 and err_o = 1 until rst_n low.
5. Assert rst_n low mid-stream with 10 in flight → outputs 0 and inflight_o = 0 immediately. Stale results in the next 24 cycles produce no res_val_o and no err_o.
6. Run 1024 samples across 4 channels through the real CalAngle against the golden angle file → every result's channel and angle match the reference within ±1 LSB; err_o = 0.

Source files
------------

// File: rtl/cal_angle_pkg.sv
// Shared definitions for the CalAngle arbiter.
// Holds the data/angle widths, the arbiter state type and the round-robin
// pick helper used by the grant logic.
package cal_angle_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ANGLE_W = 16;
  // Widest channel vector rr_pick can search.
  localparam int unsigned MAX_CH  = 16;

  typedef enum logic [0:0] {
    StDrain = 1'b0,
    StRun   = 1'b1
  } state_e;

  // Index of the first set bit of req at or after ptr, wrapping modulo num_ch.
  // Returns 0 when no bit is set; callers qualify with |req.
  function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int unsigned       num_ch);
    logic [3:0] pick;
    logic       found;
    logic [4:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      // ptr < num_ch and i < num_ch, so a single subtract wraps the sum.
      idx = 5'(ptr) + 5'(i);
      if (32'(idx) >= num_ch) idx = idx - 5'(num_ch);
      if ((i < num_ch) && !found && req[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cal_angle_arbiter_if.sv
// Bus bundle between the sample sources, the shared CalAngle core and the
// result consumer.
//   req_*  : per-channel sample valid/ready and packed 8-bit real/imag data
//   cal_*  : issue to CalAngle (val/real/imag) and its returned val/angle
//   res_*  : tagged result pulse; inflight_o occupancy; err_o sticky error
// Modport slave is the arbiter side, master the environment side.
interface cal_angle_arbiter_if #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned MAX_INFLIGHT = 32
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [NUM_CH-1:0]                        req_val_i;
  logic [NUM_CH-1:0]                        req_rdy_o;
  logic [NUM_CH*cal_angle_pkg::DATA_W-1:0]  req_real_i;
  logic [NUM_CH*cal_angle_pkg::DATA_W-1:0]  req_imag_i;
  logic                                     cal_val_o;
  logic [cal_angle_pkg::DATA_W-1:0]         cal_real_o;
  logic [cal_angle_pkg::DATA_W-1:0]         cal_imag_o;
  logic                                     cal_val_i;
  logic [cal_angle_pkg::ANGLE_W-1:0]        cal_angle_i;
  logic                                     res_val_o;
  logic [CH_W-1:0]                          res_ch_o;
  logic [cal_angle_pkg::ANGLE_W-1:0]        res_angle_o;
  logic [CNT_W-1:0]                         inflight_o;
  logic                                     err_o;

  modport slave (
    input  req_val_i, req_real_i, req_imag_i, cal_val_i, cal_angle_i,
    output req_rdy_o, cal_val_o, cal_real_o, cal_imag_o,
           res_val_o, res_ch_o, res_angle_o, inflight_o, err_o
  );

  modport master (
    output req_val_i, req_real_i, req_imag_i, cal_val_i, cal_angle_i,
    input  req_rdy_o, cal_val_o, cal_real_o, cal_imag_o,
           res_val_o, res_ch_o, res_angle_o, inflight_o, err_o
  );

endinterface

// File: rtl/tag_fifo.sv
// In-order tag FIFO holding the channel ID of each sample in flight in CalAngle.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write a tag (accepted when not full, or when popping the same cycle)
//   pop, dout  : read the head tag (dout is valid whenever not empty)
//   count      : registered occupancy 0..DEPTH; empty/full flags derived from it
module tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // While full, a push is only safe because the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cal_angle_arbiter.sv
// Shares one CalAngle core among NUM_CH sample sources.
// Round-robin picks at most one sample per cycle, registers it into CalAngle
// and records its channel in an in-order tag FIFO; each CalAngle result pops a
// tag and is returned with its channel ID one cycle later.
//   clk, rst_n : clock, async active-low reset
//   bus        : request, CalAngle and result signals (cal_angle_arbiter_if.slave)
// After reset the block drains for PIPE_LAT cycles because CalAngle itself has
// no reset and may still emit stale results.
module cal_angle_arbiter
  import cal_angle_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CH_W         = $clog2(NUM_CH),
  parameter int unsigned MAX_INFLIGHT = 32,
  parameter int unsigned PIPE_LAT     = 24
) (
  input logic                clk,
  input logic                rst_n,
  cal_angle_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned DW    = $clog2(PIPE_LAT + 1);

  state_e               state_q, state_d;
  logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
  logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 run;

  logic [3:0]           grant_idx;
  logic [4:0]           grant_inc;
  logic [NUM_CH-1:0]    req_rdy;
  logic                 allow, push, pop;
  logic [DATA_W-1:0]    sel_real, sel_imag;

  logic                 cal_val_q;
  logic [DATA_W-1:0]    cal_real_q, cal_imag_q;
  logic                 res_val_q;
  logic [CH_W-1:0]      res_ch_q;
  logic [ANGLE_W-1:0]   res_angle_q;
  logic                 err_q;

  logic [CH_W-1:0]      fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_empty;

  // Drain / run control.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StDrain: begin
        if (drain_cnt_q == DW'(PIPE_LAT - 1)) state_d = StRun;
        else                                  drain_cnt_d = drain_cnt_q + 1'b1;
      end
      StRun:   state_d = StRun;
      default: state_d = StDrain;
    endcase
  end

  assign run = (state_q == StRun);

  // Results arriving with no tag are dropped; during drain they are ignored.
  assign pop = run & bus.cal_val_i & ~fifo_empty;

  // (count - pop) < MAX_INFLIGHT, written without a subtract since count <= MAX.
  assign allow = run & (pop | (fifo_count < CNT_W'(MAX_INFLIGHT)));

  assign grant_idx = rr_pick(16'(bus.req_val_i), 4'(rr_ptr_q), NUM_CH);
  assign grant_inc = {1'b0, grant_idx} + 5'd1;

  always_comb begin
    req_rdy  = '0;
    sel_real = '0;
    sel_imag = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      req_rdy[k] = allow & bus.req_val_i[k] & (grant_idx == 4'(k));
      if (grant_idx == 4'(k)) begin
        sel_real = bus.req_real_i[k*DATA_W +: DATA_W];
        sel_imag = bus.req_imag_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign push = |req_rdy;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (grant_inc == 5'(NUM_CH)) ? '0 : grant_inc[CH_W-1:0];
  end

  tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (grant_idx[CH_W-1:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StDrain;
      drain_cnt_q <= '0;
      rr_ptr_q    <= '0;
      cal_val_q   <= 1'b0;
      cal_real_q  <= '0;
      cal_imag_q  <= '0;
      res_val_q   <= 1'b0;
      res_ch_q    <= '0;
      res_angle_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      cal_val_q   <= push;
      if (push) begin
        cal_real_q <= sel_real;
        cal_imag_q <= sel_imag;
      end
      res_val_q <= pop;
      if (pop) begin
        res_ch_q    <= fifo_dout;
        res_angle_q <= bus.cal_angle_i;
      end
      if (run & bus.cal_val_i & fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.req_rdy_o   = req_rdy;
  assign bus.cal_val_o   = cal_val_q;
  assign bus.cal_real_o  = cal_real_q;
  assign bus.cal_imag_o  = cal_imag_q;
  assign bus.res_val_o   = res_val_q;
  assign bus.res_ch_o    = res_ch_q;
  assign bus.res_angle_o = res_angle_q;
  assign bus.inflight_o  = fifo_count;
  assign bus.err_o       = err_q;

endmodule
